// File: rtl/sdu_dump_pkg.sv
`default_nettype none
// ============================================================================
// Package : sdu_pkg
// Brief   : Shared op codes, ASCII constants and state encoding for sdu_dump.
// Rev     : 1.0  initial release
// ============================================================================
package sdu_pkg;

    // Command op codes
    localparam logic SDU_OP_REG  = 1'b0;
    localparam logic SDU_OP_DMEM = 1'b1;

    // ASCII characters used in the dump stream
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h61;

    // Dump FSM states; ST_PREFIX is only reachable in the prefix build
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_CAPT   = 3'd2,
        ST_PREFIX = 3'd3,
        ST_HEX    = 3'd4,
        ST_SEP    = 3'd5
    } sdu_state_e;

endpackage : sdu_pkg
`default_nettype wire

// File: rtl/sdu_dump_hex_ascii.sv
`default_nettype none
// ============================================================================
// Module  : hex_ascii
// Brief   : Combinational 4-bit nibble to lowercase ASCII hex character.
// Rev     : 1.0  initial release
// ============================================================================
module hex_ascii
    import sdu_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    // 0-9 map onto '0'..'9', 10-15 onto 'a'..'f'
    always_comb begin
        if (nib < 4'd10) begin
            ascii = ASCII_ZERO + {4'b0000, nib};
        end else begin
            ascii = ASCII_A + ({4'b0000, nib} - 8'd10);
        end
    end

endmodule : hex_ascii
`default_nettype wire

// File: rtl/sdu_dump.sv
`default_nettype none
// ============================================================================
// Module  : sdu_dump
// Brief   : Walks the CPU register file or data memory through the SDU debug
//           read ports and streams each word as a lowercase ASCII hex line
//           on a byte valid/ready interface toward the UART transmitter.
//           Optional macro SDU_DUMP_PREFIX_EN prefixes each line with
//           "<index>: ".
// Rev     : 1.0  initial release
// ============================================================================
module sdu_dump
    import sdu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    output logic [4:0]  rra0,
    input  logic [31:0] rrd0,
    output logic [31:0] dra0,
    input  logic [31:0] drd0,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    sdu_state_e  state_q, state_d;
    logic        op_q,    op_d;
    logic [31:0] idx_q,   idx_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [31:0] cap_q,   cap_d;
    logic [2:0]  nib_q,   nib_d;
    logic [4:0]  rra0_q,  rra0_d;
    logic [31:0] dra0_q,  dra0_d;
    logic        done_q,  done_d;
`ifdef SDU_DUMP_PREFIX_EN
    // 0: index nibbles, 1: colon, 2: space
    logic [1:0]  sub_q,   sub_d;
`endif

    logic [31:0] idx_next;
    logic [31:0] nib_src;
    logic [31:0] nib_shifted;
    logic [4:0]  nib_shamt;
    logic [3:0]  hex_in;
    logic [7:0]  hex_out;
    logic        xfer;

    hex_ascii u_hex_ascii (
        .nib   (hex_in),
        .ascii (hex_out)
    );

    // Next index: register numbers wrap in 5 bits, memory words in 32 bits
    always_comb begin
        if (op_q == SDU_OP_REG) begin
            idx_next = {27'd0, idx_q[4:0] + 5'd1};
        end else begin
            idx_next = idx_q + 32'd1;
        end
    end

    // Select the nibble (MSB first) feeding the single hex converter
    always_comb begin
        nib_src = cap_q;
`ifdef SDU_DUMP_PREFIX_EN
        if (state_q == ST_PREFIX) begin
            nib_src = idx_q;
        end
`endif
        nib_shamt   = 5'd28 - {nib_q, 2'b00};
        nib_shifted = nib_src >> nib_shamt;
        hex_in      = nib_shifted[3:0];
    end

    // Byte output mux; all non-emitting states present a zero byte
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            ST_HEX: begin
                tx_valid = 1'b1;
                tx_data  = hex_out;
            end
            ST_SEP: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_LF;
            end
`ifdef SDU_DUMP_PREFIX_EN
            ST_PREFIX: begin
                tx_valid = 1'b1;
                case (sub_q)
                    2'd1:    tx_data = ASCII_COLON;
                    2'd2:    tx_data = ASCII_SPACE;
                    default: tx_data = hex_out;
                endcase
            end
`endif
            default: ;
        endcase
    end

    assign xfer      = tx_valid & tx_ready;
    assign cmd_ready = (state_q == ST_IDLE);
    assign rra0      = rra0_q;
    assign dra0      = dra0_q;
    assign done      = done_q;

    // Next-state logic: command accept, word walk and byte sequencing
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        nib_d   = nib_q;
        rra0_d  = rra0_q;
        dra0_d  = dra0_q;
        done_d  = 1'b0;
`ifdef SDU_DUMP_PREFIX_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    idx_d = (cmd_op == SDU_OP_REG) ? {27'd0, cmd_addr[4:0]} : cmd_addr;
                    cnt_d = cmd_len;
                    if (cmd_len == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                        if (cmd_op == SDU_OP_REG) begin
                            rra0_d = cmd_addr[4:0];
                        end else begin
                            dra0_d = cmd_addr;
                        end
                    end
                end
            end
            ST_ADDR: begin
                cap_d   = (op_q == SDU_OP_REG) ? rrd0 : drd0;
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                nib_d = 3'd0;
`ifdef SDU_DUMP_PREFIX_EN
                sub_d   = 2'd0;
                state_d = ST_PREFIX;
`else
                state_d = ST_HEX;
`endif
            end
`ifdef SDU_DUMP_PREFIX_EN
            ST_PREFIX: begin
                if (xfer) begin
                    case (sub_q)
                        2'd0: begin
                            if (nib_q == 3'd7) begin
                                nib_d = 3'd0;
                                sub_d = 2'd1;
                            end else begin
                                nib_d = nib_q + 3'd1;
                            end
                        end
                        2'd1: sub_d = 2'd2;
                        default: begin
                            sub_d   = 2'd0;
                            nib_d   = 3'd0;
                            state_d = ST_HEX;
                        end
                    endcase
                end
            end
`endif
            ST_HEX: begin
                if (xfer) begin
                    if (nib_q == 3'd7) begin
                        state_d = ST_SEP;
                    end else begin
                        nib_d = nib_q + 3'd1;
                    end
                end
            end
            ST_SEP: begin
                if (xfer) begin
                    cnt_d = cnt_q - 8'd1;
                    idx_d = idx_next;
                    if (cnt_q == 8'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ADDR;
                        if (op_q == SDU_OP_REG) begin
                            rra0_d = idx_next[4:0];
                        end else begin
                            dra0_d = idx_next;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            op_q    <= SDU_OP_REG;
            idx_q   <= 32'd0;
            cnt_q   <= 8'd0;
            cap_q   <= 32'd0;
            nib_q   <= 3'd0;
            rra0_q  <= 5'd0;
            dra0_q  <= 32'd0;
            done_q  <= 1'b0;
`ifdef SDU_DUMP_PREFIX_EN
            sub_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            nib_q   <= nib_d;
            rra0_q  <= rra0_d;
            dra0_q  <= dra0_d;
            done_q  <= done_d;
`ifdef SDU_DUMP_PREFIX_EN
            sub_q   <= sub_d;
`endif
        end
    end

endmodule : sdu_dump
`default_nettype wire

// File: tb/tb_sdu_dump.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdu_dump
// Brief   : Self-checking bench for sdu_dump: table of dump commands with
//           hand-computed byte streams plus reset-during-dump sequence.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sdu_dump;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [4:0]  rra0;
    logic [31:0] rrd0;
    logic [31:0] dra0;
    logic [31:0] drd0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdu_dump dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rra0      (rra0),
        .rrd0      (rrd0),
        .dra0      (dra0),
        .drd0      (drd0),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (done)
    );

    // Register file contents: r2 = 0xab, others 0x0f0e00<reg>
    always_comb begin
        if (rra0 == 5'd2) rrd0 = 32'h0000_00AB;
        else              rrd0 = {16'h0f0e, 11'd0, rra0};
    end

    // Data memory contents: a few fixed words, others index ^ 0xa5a5a5a5
    always_comb begin
        case (dra0)
            32'h0000_0100: drd0 = 32'hDEAD_BEEF;
            32'h0000_0101: drd0 = 32'h1234_5678;
            32'h0000_0010: drd0 = 32'h0000_0001;
            default:       drd0 = dra0 ^ 32'hA5A5_A5A5;
        endcase
    end

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [7:0]  len;
        bit          rnd_ready;
        bit          hold_valid;
        string       l0;
        string       l1;
        string       l2;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] a2;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic op, input logic [31:0] addr, input logic [7:0] len,
                           input bit rnd, input bit hold,
                           input string l0, input string l1, input string l2,
                           input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        vec_t v;
        v.op = op; v.addr = addr; v.len = len; v.rnd_ready = rnd; v.hold_valid = hold;
        v.l0 = l0; v.l1 = l1; v.l2 = l2; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        vq.push_back(v);
    endtask

    function automatic string pfx(input logic [31:0] idx);
`ifdef SDU_DUMP_PREFIX_EN
        return $sformatf("%08x: ", idx);
`else
        return "";
`endif
    endfunction

    function automatic int line_cycles();
`ifdef SDU_DUMP_PREFIX_EN
        return 21;
`else
        return 11;
`endif
    endfunction

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_vec(input int k);
        vec_t        v;
        string       got;
        string       exp;
        logic [31:0] addrs[$];
        logic [31:0] exp_addr[3];
        int          cyc;
        int          done_at;
        int          accepts;
        int          exp_done;
        bit          prev_stall;
        logic [7:0]  prev_data;
        int          bad_pos;
        v = vq[k];
        exp_addr[0] = v.a0; exp_addr[1] = v.a1; exp_addr[2] = v.a2;
        exp = "";
        if (v.len > 0) exp = {exp, pfx(v.a0), v.l0};
        if (v.len > 1) exp = {exp, pfx(v.a1), v.l1};
        if (v.len > 2) exp = {exp, pfx(v.a2), v.l2};
        exp_done = (v.len == 0) ? 1 : (int'(v.len) * line_cycles() + 1);
        got = ""; done_at = -1; accepts = 0; prev_stall = 1'b0; prev_data = 8'h00;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_len = v.len;
        tx_ready  = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cmd_valid && cmd_ready) accepts++;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                chk($sformatf("v%0d stall_valid", k), {31'd0, tx_valid}, 32'd1);
                chk($sformatf("v%0d stall_data", k), {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (done) begin
                done_at = cyc;
                cmd_valid = 1'b0;
                chk($sformatf("v%0d ready_at_done", k), {31'd0, cmd_ready}, 32'd1);
                break;
            end
            if (!v.hold_valid) cmd_valid = 1'b0;
            tx_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) begin
                got = $sformatf("%s%c", got, tx_data);
                if (tx_data == 8'h0A) addrs.push_back(v.op ? dra0 : {27'd0, rra0});
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (cmd_valid && cmd_ready) accepts++;
        end
        cmd_valid = 1'b0;
        tx_ready  = 1'b1;
        if (done_at < 0) begin
            checks++; failures++;
            $display("FAIL v%0d timeout: no done within %0d cycles", k, cyc);
        end
        if (!v.rnd_ready) chk($sformatf("v%0d done_cycle", k), done_at, exp_done);
        chk($sformatf("v%0d accepts", k), accepts, 1);
        chk($sformatf("v%0d byte_count", k), got.len(), exp.len());
        bad_pos = -1;
        for (int i = 0; i < exp.len() && i < got.len(); i++) begin
            if (bad_pos < 0 && got[i] != exp[i]) bad_pos = i;
        end
        checks++;
        if (bad_pos >= 0) begin
            failures++;
            $display("FAIL v%0d bytes pos %0d: got %02h want %02h", k, bad_pos, got[bad_pos], exp[bad_pos]);
        end
        chk($sformatf("v%0d line_count", k), addrs.size(), {24'd0, v.len});
        for (int i = 0; i < addrs.size() && i < 3; i++) begin
            chk($sformatf("v%0d addr%0d", k, i), addrs[i], exp_addr[i]);
        end
        // done must be a single-cycle pulse
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", k), {31'd0, done}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, " tx_valid"},  {31'd0, tx_valid},  32'd0);
        chk({tag, " tx_data"},   {24'd0, tx_data},   32'd0);
        chk({tag, " rra0"},      {27'd0, rra0},      32'd0);
        chk({tag, " dra0"},      dra0,               32'd0);
        chk({tag, " done"},      {31'd0, done},      32'd0);
    endtask

    task automatic reset_mid_dump();
        int nbytes;
        int guard;
        bit saw_done;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'h0000_0100; cmd_len = 8'd2;
        tx_ready = 1'b1;
        nbytes = 0; guard = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (nbytes < 4 && guard < 200) begin
            if (tx_valid && tx_ready) nbytes++;
            @(negedge clk);
            guard++;
        end
        chk("rst_mid bytes_before", nbytes, 4);
        chk("rst_mid busy", {31'd0, cmd_ready}, 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rstn = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || tx_valid) saw_done = 1'b1;
        end
        chk("rst_mid quiet_after", {31'd0, saw_done}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
        tx_ready = 1'b1;

        add_vec(1'b0, 32'd2,          8'd1, 1'b0, 1'b0, "000000ab\n", "", "", 32'd2, 32'd0, 32'd0);
        add_vec(1'b0, 32'd30,         8'd3, 1'b0, 1'b0, "0f0e001e\n", "0f0e001f\n", "0f0e0000\n", 32'd30, 32'd31, 32'd0);
        add_vec(1'b1, 32'h100,        8'd2, 1'b0, 1'b0, "deadbeef\n", "12345678\n", "", 32'h100, 32'h101, 32'd0);
        add_vec(1'b1, 32'h100,        8'd2, 1'b1, 1'b0, "deadbeef\n", "12345678\n", "", 32'h100, 32'h101, 32'd0);
        add_vec(1'b0, 32'd5,          8'd0, 1'b0, 1'b1, "", "", "", 32'd0, 32'd0, 32'd0);
        add_vec(1'b1, 32'h10,         8'd1, 1'b0, 1'b1, "00000001\n", "", "", 32'h10, 32'd0, 32'd0);
        add_vec(1'b1, 32'hFFFF_FFFF,  8'd2, 1'b0, 1'b0, "5a5a5a5a\n", "a5a5a5a5\n", "", 32'hFFFF_FFFF, 32'd0, 32'd0);
        add_vec(1'b0, 32'h0000_0021,  8'd1, 1'b0, 1'b0, "0f0e0001\n", "", "", 32'd1, 32'd0, 32'd0);
        add_vec(1'b1, 32'h100,        8'd2, 1'b1, 1'b1, "deadbeef\n", "12345678\n", "", 32'h100, 32'h101, 32'd0);

        apply_reset();
        @(negedge clk);
        check_idle_outputs("reset");

        for (int k = 0; k < vq.size(); k++) begin
            run_vec(k);
        end

        reset_mid_dump();

        // A command after the abandoned dump still works normally
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sdu_dump
`default_nettype wire
